// File: rtl/regfile_gen_pkg.sv
// Shared types and next-state function for the regfile_gen register file.
// Optional bypass is enabled by defining REGFILE_GEN_BYPASS_EN.
package regfile_gen_pkg;

    // Widest register the next-state helper can serve; DATA_W must not exceed it.
    localparam int unsigned MAX_W = 128;

    typedef enum logic [2:0] {
        FS_DEC          = 3'b000,
        FS_INC          = 3'b001,
        FS_LOAD         = 3'b010,
        FS_CLR          = 3'b011,
        FS_LOADLO_CLRHI = 3'b100,
        FS_LOADLO       = 3'b101,
        FS_LOADHI       = 3'b110,
        FS_SEXT         = 3'b111
    } fun_sel_e;

    typedef struct packed {
        logic [MAX_W-1:0] value;
        logic             wrap;
    } next_t;

    // Operands live in the low 'width' bits of MAX_W-wide vectors.
    function automatic next_t calc_next(input logic [MAX_W-1:0] cur,
                                        input logic [MAX_W-1:0] din,
                                        input fun_sel_e         fs,
                                        input int unsigned      width);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] lo_mask;
        logic [MAX_W-1:0] hi_mask;
        logic [MAX_W-1:0] din_lo;
        logic [MAX_W-1:0] cur_m;
        logic             sign;
        int unsigned      half;
        next_t            res;

        half    = width / 2;
        mask    = {MAX_W{1'b1}} >> (MAX_W - width);
        lo_mask = {MAX_W{1'b1}} >> (MAX_W - half);
        hi_mask = mask & ~lo_mask;
        din_lo  = din & lo_mask;
        cur_m   = cur & mask;
        // Top bit of the low half, found without a variable index.
        sign    = |(din & (lo_mask ^ (lo_mask >> 1)));

        res.value = '0;
        res.wrap  = 1'b0;
        unique case (fs)
            FS_DEC: begin
                res.value = (cur_m - MAX_W'(1)) & mask;
                res.wrap  = (cur_m == '0);
            end
            FS_INC: begin
                res.value = (cur_m + MAX_W'(1)) & mask;
                res.wrap  = (cur_m == mask);
            end
            FS_LOAD:         res.value = din & mask;
            FS_CLR:          res.value = '0;
            FS_LOADLO_CLRHI: res.value = din_lo;
            FS_LOADLO:       res.value = (cur_m & hi_mask) | din_lo;
            FS_LOADHI:       res.value = (cur_m & lo_mask) | ((din_lo << half) & hi_mask);
            FS_SEXT:         res.value = din_lo | (sign ? hi_mask : '0);
            default: begin
                res.value = '0;
                res.wrap  = 1'b0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/regfile_gen_cell.sv
// One register of regfile_gen together with its sticky wrap flag.
// Read view honours REGFILE_GEN_BYPASS_EN (next-state forwarded when enabled).
module regfile_gen_cell
    import regfile_gen_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  fun_sel_e          fun_sel_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] rd_o,
    output logic              wrap_o
);

    logic [DATA_W-1:0] value_q, value_d;
    logic              wrap_q, wrap_d;
    next_t             res;

    always_comb begin
        res     = calc_next(MAX_W'(value_q), MAX_W'(din_i), fun_sel_i, DATA_W);
        value_d = value_q;
        wrap_d  = wrap_q;
        if (en_i) begin
            value_d = DATA_W'(res.value);
            if (fun_sel_i == FS_CLR) begin
                wrap_d = 1'b0;
            end else if (res.wrap) begin
                wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            value_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef REGFILE_GEN_BYPASS_EN
    // Forwarded value must not leak through while reset holds the state at zero.
    assign rd_o = rst_i ? '0 : (en_i ? value_d : value_q);
`else
    assign rd_o = value_q;
`endif

    assign wrap_o = wrap_q;

endmodule

// File: rtl/regfile_gen.sv
// Parameterised register file with per-register FunSel ops and two read ports.
// Define REGFILE_GEN_BYPASS_EN for zero-cycle read-after-write on the read ports.
module regfile_gen
    import regfile_gen_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 8,
    localparam int unsigned SEL_W   = $clog2(NUM_REGS)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [DATA_W-1:0]   I,
    input  logic [2:0]          FunSel,
    input  logic [NUM_REGS-1:0] RegSel,
    input  logic [SEL_W-1:0]    OutASel,
    input  logic [SEL_W-1:0]    OutBSel,
    output logic [DATA_W-1:0]   OutA,
    output logic [DATA_W-1:0]   OutB,
    output logic [NUM_REGS-1:0] WrapFlag
);

    logic [DATA_W-1:0] rd [NUM_REGS];
    fun_sel_e          fun_sel;

    assign fun_sel = fun_sel_e'(FunSel);

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        regfile_gen_cell #(
            .DATA_W (DATA_W)
        ) u_cell (
            .clk_i     (Clock),
            .rst_i     (Reset),
            .en_i      (RegSel[k]),
            .fun_sel_i (fun_sel),
            .din_i     (I),
            .rd_o      (rd[k]),
            .wrap_o    (WrapFlag[k])
        );
    end

    // Selects that match no register fall through to zero.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int k = 0; k < int'(NUM_REGS); k++) begin
            if (OutASel == SEL_W'(k)) OutA = rd[k];
            if (OutBSel == SEL_W'(k)) OutB = rd[k];
        end
    end

endmodule

// File: tb/tb_regfile_gen.sv
// Directed self-checking bench for regfile_gen (8-register and 6-register builds).
module tb_regfile_gen;

`ifdef REGFILE_GEN_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] I;
    logic [2:0]  FunSel;
    logic [7:0]  RegSel;
    logic [2:0]  OutASel, OutBSel;
    logic [31:0] OutA, OutB;
    logic [7:0]  WrapFlag;

    logic [5:0]  RegSel6;
    logic [2:0]  OutASel6, OutBSel6;
    logic [31:0] OutA6, OutB6;
    logic [5:0]  WrapFlag6;

    int checks = 0;
    int errors = 0;

    regfile_gen dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .I        (I),
        .FunSel   (FunSel),
        .RegSel   (RegSel),
        .OutASel  (OutASel),
        .OutBSel  (OutBSel),
        .OutA     (OutA),
        .OutB     (OutB),
        .WrapFlag (WrapFlag)
    );

    regfile_gen #(
        .DATA_W   (32),
        .NUM_REGS (6)
    ) dut6 (
        .Clock    (Clock),
        .Reset    (Reset),
        .I        (I),
        .FunSel   (FunSel),
        .RegSel   (RegSel6),
        .OutASel  (OutASel6),
        .OutBSel  (OutBSel6),
        .OutA     (OutA6),
        .OutB     (OutB6),
        .WrapFlag (WrapFlag6)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Commit whatever is driven on the next edge, then drop all enables.
    task automatic step();
        @(posedge Clock);
        #1;
        RegSel  = '0;
        RegSel6 = '0;
        #1;
    endtask

    task automatic half_op_reg3(input logic [2:0] op, input logic [31:0] exp, input string tag);
        RegSel = 8'h08; FunSel = 3'b010; I = 32'hAAAA_BBBB;
        step();
        RegSel = 8'h08; FunSel = op; I = 32'h0000_8001;
        step();
        OutASel = 3'd3;
        #1;
        check(tag, OutA, exp);
    endtask

    initial begin
        Reset = 1'b1; I = '0; FunSel = '0; RegSel = '0; OutASel = '0; OutBSel = '0;
        RegSel6 = '0; OutASel6 = '0; OutBSel6 = '0;
        #1;
        check("reset_outa", OutA, 32'h0);
        check("reset_wrap", WrapFlag, 8'h00);
        check("reset_outa6", OutA6, 32'h0);
        @(negedge Clock);
        Reset = 1'b0;

        // Read-after-write latency on register 0
        RegSel = 8'h01; FunSel = 3'b010; I = 32'h1234_5678; OutASel = 3'd0;
        #1;
        check("raw_same_cycle", OutA, BYP ? 32'h1234_5678 : 32'h0);
        step();
        check("raw_next_cycle", OutA, 32'h1234_5678);

        // Increment wrap on register 2 and sticky flag behaviour
        RegSel = 8'h04; FunSel = 3'b010; I = 32'hFFFF_FFFF;
        step();
        RegSel = 8'h04; FunSel = 3'b001;
        step();
        OutBSel = 3'd2;
        #1;
        check("inc_wrap_value", OutB, 32'h0);
        check("inc_wrap_flag", WrapFlag, 8'h04);
        RegSel = 8'h04; FunSel = 3'b010; I = 32'h0000_0005;
        step();
        check("load_after_wrap", OutB, 32'h5);
        check("wrap_sticky", WrapFlag, 8'h04);
        RegSel = 8'h04; FunSel = 3'b011;
        step();
        check("clr_value", OutB, 32'h0);
        check("clr_wrap_flag", WrapFlag, 8'h00);

        // Half-word operations on register 3
        half_op_reg3(3'b110, 32'h8001_BBBB, "loadhi");
        half_op_reg3(3'b111, 32'hFFFF_8001, "sext");
        half_op_reg3(3'b100, 32'h0000_8001, "loadlo_clrhi");
        half_op_reg3(3'b101, 32'hAAAA_8001, "loadlo");

        OutASel = 3'd0;
        #1;
        check("hold_reg0", OutA, 32'h1234_5678);

        // Decrement wrap on register 1 (from 0)
        RegSel = 8'h02; FunSel = 3'b000;
        step();
        OutASel = 3'd1; OutBSel = 3'd0;
        #1;
        check("dec_wrap_value", OutA, 32'hFFFF_FFFF);
        check("dec_wrap_flag", WrapFlag, 8'h02);

        // Asynchronous reset pulse between clock edges
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_outa", OutA, 32'h0);
        check("async_rst_outb", OutB, 32'h0);
        check("async_rst_wrap", WrapFlag, 8'h00);
        #1;
        Reset = 1'b0;

        // Reset held across an enabled edge: no write commits
        RegSel = 8'hFF; FunSel = 3'b010; I = 32'hDEAD_BEEF; Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("rst_during_write", OutA, 32'h0);
        Reset = 1'b0; RegSel = '0;
        #1;
        check("rst_wins_outa", OutA, 32'h0);
        check("rst_wins_outb", OutB, 32'h0);

        // Decrement every register from reset
        RegSel = 8'hFF; FunSel = 3'b000;
        step();
        for (int k = 0; k < 8; k++) begin
            OutASel = 3'(k);
            OutBSel = 3'(7 - k);
            #1;
            check("dec_all_outa", OutA, 32'hFFFF_FFFF);
            check("dec_all_outb", OutB, 32'hFFFF_FFFF);
        end
        check("dec_all_wrap", WrapFlag, 8'hFF);

        // Six-register build: out-of-range selects and shared port select
        RegSel6 = 6'h20; FunSel = 3'b010; I = 32'hCAFE_0005;
        step();
        OutASel6 = 3'd5; OutBSel6 = 3'd5;
        #1;
        check("n6_same_sel_a", OutA6, 32'hCAFE_0005);
        check("n6_same_sel_b", OutB6, 32'hCAFE_0005);
        OutASel6 = 3'd7;
        #1;
        check("n6_sel7_zero", OutA6, 32'h0);
        OutASel6 = 3'd6;
        #1;
        check("n6_sel6_zero", OutA6, 32'h0);
        check("n6_wrap", WrapFlag6, 6'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
